regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised general-purpose register file with registered multi-port reads, write-to-read bypass, hardwired zero register and an integrated per-register pending scoreboard. It sits between decode and writeback in the MIPS core pipeline. Decode reads operands and learns in the same access whether any source is still awaiting writeback. It is the generalised successor of the core's 2-read/1-write register file.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth NREG = 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads as 0, is never written and is never pending

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  writeback enable
- waddr  in  ADDR_W  writeback register address
- wdata  in  DATA_W  writeback data
- iss_v  in  1  issue valid; marks iss_addr pending
- iss_addr  in  ADDR_W  destination register of issuing instruction
- re  in  NRD  per-port read enable
- raddr  in  NRD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rdata  out  NRD*DATA_W  registered read data; port i at [i*DATA_W +: DATA_W]
- rbusy  out  NRD  registered; source of port i was pending when sampled
- stall  out  1  registered; OR of rbusy over ports whose re was high
- pend_cnt  out  ADDR_W+1  registered count of pending registers

## Operation
- Storage: NREG x DATA_W registers and NREG pending bits.
- Write: on rising clk with we=1, regs[waddr] <= wdata. Suppressed when ZERO_REG=1 and waddr=0.
- Writeback clears pending[waddr] whether or not the data write is suppressed.
- Issue: iss_v=1 sets pending[iss_addr]. It is ignored for address 0 when ZERO_REG=1.
- Same-cycle issue and writeback to the same address: the issue wins and the bit ends set, because the new producer supersedes the old.
- Read port i with re[i]=1 on edge N:
  - rdata_i <= (we && waddr==raddr_i && !(ZERO_REG && raddr_i==0)) ? wdata : regs[raddr_i], i.e. write-first bypass.
  - rdata_i <= 0 when ZERO_REG=1 and raddr_i=0.
  - rbusy_i <= pending[raddr_i] && !(we && waddr==raddr_i). A same-cycle writeback is visible; a same-cycle issue is not.
- Port with re[i]=0: rdata_i and rbusy_i hold their previous values. Hold is not clear.
- stall <= OR over i of (re[i] && next rbusy_i). When no port is enabled, stall <= 0.
- Multiple ports may read the same address in the same cycle; each gets the identical value.
- pend_cnt <= popcount of the next pending vector. It saturates naturally at NREG-ZERO_REG.
- Reset (rst=1, asynchronous): all regs 0, all pending 0, rdata 0, rbusy 0, stall 0, pend_cnt 0.
  - Reset mid-operation discards all in-flight writes and issues.
  - No update occurs on an edge while rst is high.

## Timing
- Read latency 1 cycle: address sampled on edge N, data valid after edge N until the next enabled read.
- Write latency 1 cycle. Bypass makes written data visible to a read sampled on the same edge.
- Scoreboard set/clear take effect on the edge they are presented on. A read on edge N+1 or later sees the new state.
- The pend_cnt, stall and rbusy paths are all registered; none are combinational from inputs.
- Single write port. At most one issue per cycle.

## Test plan
- Reset then read all 32 registers on 2 ports -> rdata 0, rbusy 0, stall 0, pend_cnt 0 on every cycle.
- Bypass: we=1, waddr=5, wdata=0xDEADBEEF with re=2'b11, raddr0=raddr1=5 on the same edge -> both rdata = 0xDEADBEEF one cycle later. A later read of r5 returns the same value.
- Zero register: write 0x1234 to r0 and issue r0 -> a read of r0 returns 0, rbusy 0, pend_cnt unchanged.
- Scoreboard flow:
  - Issue r7 -> pend_cnt=1; read r7 -> rbusy0=1, stall=1.
  - Writeback r7 with a same-edge read of r7 -> rbusy0=0, stall=0, data bypassed, pend_cnt=0.
- Collision: iss_v and we both to r9 on one edge -> pending[9] stays 1 and pend_cnt increments.
  - A read with re=0 on the following cycle -> rdata/rbusy hold their prior values.
- Asynchronous reset mid-operation: with 3 registers pending and r3=0xA5A5A5A5, assert rst between edges -> all outputs 0 immediately. After deassert, reading r3 returns 0 and pend_cnt is 0.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register-file bus: writeback, issue and multi-port read signals between
// the pipeline (master) and the register file with scoreboard (slave).
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) ();
  logic                    we;
  logic [ADDR_W-1:0]       waddr;
  logic [DATA_W-1:0]       wdata;
  logic                    iss_v;
  logic [ADDR_W-1:0]       iss_addr;
  logic [NRD-1:0]          re;
  logic [NRD*ADDR_W-1:0]   raddr;
  logic [NRD*DATA_W-1:0]   rdata;
  logic [NRD-1:0]          rbusy;
  logic                    stall;
  logic [ADDR_W:0]         pend_cnt;

  modport master (
    output we, waddr, wdata, iss_v, iss_addr, re, raddr,
    input  rdata, rbusy, stall, pend_cnt
  );

  modport slave (
    input  we, waddr, wdata, iss_v, iss_addr, re, raddr,
    output rdata, rbusy, stall, pend_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// General-purpose register file with registered multi-port reads, write-first
// bypass, optional hardwired zero register and a per-register pending scoreboard.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  localparam int NREG = 1 << ADDR_W;
  localparam bit ZR   = (ZERO_REG != 0);

  logic [DATA_W-1:0]     regs [NREG];
  logic [NREG-1:0]       pend;
  logic [NREG-1:0]       pend_nxt;

  logic [ADDR_W-1:0]     ra [NRD];
  logic [NRD-1:0]        hit;
  logic                  wr_ok;
  logic                  iss_ok;

  logic [NRD*DATA_W-1:0] rdata_nxt;
  logic [NRD-1:0]        rbusy_nxt;
  logic                  stall_nxt;

  logic [NRD*DATA_W-1:0] rdata_p1;
  logic [NRD-1:0]        rbusy_p1;
  logic                  stall_p1;
  logic [ADDR_W:0]       pend_cnt_p1;

  function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + (ADDR_W+1)'(v[i]);
    end
    return c;
  endfunction

  assign wr_ok  = bus.we && !(ZR && bus.waddr == '0);
  assign iss_ok = bus.iss_v && !(ZR && bus.iss_addr == '0);

  for (genvar g = 0; g < NRD; g++) begin : g_port
    assign ra[g]  = bus.raddr[g*ADDR_W +: ADDR_W];
    assign hit[g] = bus.we && (bus.waddr == ra[g]);
  end

  // Issue is applied after writeback so a colliding new producer stays pending.
  always_comb begin
    pend_nxt = pend;
    if (bus.we) pend_nxt[bus.waddr] = 1'b0;
    if (iss_ok) pend_nxt[bus.iss_addr] = 1'b1;
    if (ZR) pend_nxt[0] = 1'b0;
  end

  // Disabled ports keep their last result; busy ignores a same-edge issue.
  always_comb begin
    rdata_nxt = rdata_p1;
    rbusy_nxt = rbusy_p1;
    stall_nxt = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (bus.re[i]) begin
        if (ZR && ra[i] == '0) begin
          rdata_nxt[i*DATA_W +: DATA_W] = '0;
        end else if (hit[i]) begin
          rdata_nxt[i*DATA_W +: DATA_W] = bus.wdata;
        end else begin
          rdata_nxt[i*DATA_W +: DATA_W] = regs[ra[i]];
        end
        rbusy_nxt[i] = pend[ra[i]] && !hit[i];
        stall_nxt    = stall_nxt | rbusy_nxt[i];
      end
    end
  end

  // Stage p1: storage, scoreboard and registered read results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
      pend        <= '0;
      rdata_p1    <= '0;
      rbusy_p1    <= '0;
      stall_p1    <= 1'b0;
      pend_cnt_p1 <= '0;
    end else begin
      if (wr_ok) regs[bus.waddr] <= bus.wdata;
      pend        <= pend_nxt;
      rdata_p1    <= rdata_nxt;
      rbusy_p1    <= rbusy_nxt;
      stall_p1    <= stall_nxt;
      pend_cnt_p1 <= popcount(pend_nxt);
    end
  end

  assign bus.rdata    = rdata_p1;
  assign bus.rbusy    = rbusy_p1;
  assign bus.stall    = stall_p1;
  assign bus.pend_cnt = pend_cnt_p1;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reference model of the register file and
// scoreboard compared every cycle, plus hand-computed literal expectations.
module tb_regfile_sb;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 2;
  localparam int NRG = 32;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) bus ();

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] m_regs [NRG];
  bit            m_pend [NRG];
  logic [DW-1:0] m_rdata [NR];
  bit            m_rbusy [NR];
  bit            m_stall;
  int            m_cnt;
  int            ma;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return bus.rdata[p*DW +: DW];
  endfunction

  // Model: apply writeback, then sample reads, then apply issue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NRG; r++) begin
        m_regs[r] = '0;
        m_pend[r] = 1'b0;
      end
      for (int p = 0; p < NR; p++) begin
        m_rdata[p] = '0;
        m_rbusy[p] = 1'b0;
      end
      m_stall = 1'b0;
      m_cnt   = 0;
    end else begin
      if (bus.we) begin
        if (bus.waddr != 0) m_regs[bus.waddr] = bus.wdata;
        m_pend[bus.waddr] = 1'b0;
      end
      m_stall = 1'b0;
      for (int p = 0; p < NR; p++) begin
        if (bus.re[p]) begin
          ma = int'(bus.raddr[p*AW +: AW]);
          m_rdata[p] = (ma == 0) ? '0 : m_regs[ma];
          m_rbusy[p] = m_pend[ma];
          if (m_rbusy[p]) m_stall = 1'b1;
        end
      end
      if (bus.iss_v && bus.iss_addr != 0) m_pend[bus.iss_addr] = 1'b1;
      m_cnt = 0;
      for (int r = 0; r < NRG; r++) m_cnt += int'(m_pend[r]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NR; p++) begin
        check($sformatf("model_rdata%0d", p), 64'(rd(p)), 64'(m_rdata[p]));
        check($sformatf("model_rbusy%0d", p), 64'(bus.rbusy[p]), 64'(m_rbusy[p]));
      end
      check("model_stall", 64'(bus.stall), 64'(m_stall));
      check("model_pend_cnt", 64'(bus.pend_cnt), 64'(m_cnt));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.iss_v = 1'b0; bus.re = '0;
  endtask

  task automatic rd2(input logic [1:0] en, input int a0, input int a1);
    bus.re = en;
    bus.raddr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    rst = 1'b1;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.iss_v = 1'b0; bus.iss_addr = '0;
    bus.re = '0; bus.raddr = '0;
    cyc(); cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    cyc();
    check("reset_rdata0", 64'(rd(0)), 64'h0);
    check("reset_pend_cnt", 64'(bus.pend_cnt), 64'h0);

    // Read every register on both ports after reset
    for (int i = 0; i < NRG; i++) begin
      rd2(2'b11, i, NRG-1-i);
      cyc();
      check("reset_read_rbusy", 64'(bus.rbusy), 64'h0);
    end
    check("reset_read_stall", 64'(bus.stall), 64'h0);

    // Bypass on both ports
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
    rd2(2'b11, 5, 5);
    cyc();
    check("bypass_rdata0", 64'(rd(0)), 64'hDEADBEEF);
    check("bypass_rdata1", 64'(rd(1)), 64'hDEADBEEF);
    idle(); rd2(2'b01, 5, 0);
    cyc();
    check("r5_later", 64'(rd(0)), 64'hDEADBEEF);

    // Zero register: write and issue are ignored
    bus.we = 1'b1; bus.waddr = '0; bus.wdata = 32'h1234;
    bus.iss_v = 1'b1; bus.iss_addr = '0;
    rd2(2'b01, 0, 0);
    cyc();
    idle(); rd2(2'b01, 0, 0);
    cyc();
    check("zero_rdata", 64'(rd(0)), 64'h0);
    check("zero_rbusy", 64'(bus.rbusy[0]), 64'h0);
    check("zero_pend_cnt", 64'(bus.pend_cnt), 64'h0);

    // Scoreboard flow on r7
    idle(); bus.iss_v = 1'b1; bus.iss_addr = 5'd7;
    cyc();
    check("iss7_pend_cnt", 64'(bus.pend_cnt), 64'd1);
    idle(); rd2(2'b01, 7, 0);
    cyc();
    check("r7_busy", 64'(bus.rbusy[0]), 64'd1);
    check("r7_stall", 64'(bus.stall), 64'd1);
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h77;
    rd2(2'b01, 7, 0);
    cyc();
    check("wb7_busy", 64'(bus.rbusy[0]), 64'd0);
    check("wb7_stall", 64'(bus.stall), 64'd0);
    check("wb7_rdata", 64'(rd(0)), 64'h77);
    check("wb7_pend_cnt", 64'(bus.pend_cnt), 64'd0);

    // Bulk: write r12..r19 while issuing r20..r27, read back, then retire
    for (int i = 12; i < 20; i++) begin
      idle();
      bus.we = 1'b1; bus.waddr = AW'(i); bus.wdata = 32'h0100_0000 * i + 32'hC0DE;
      bus.iss_v = 1'b1; bus.iss_addr = AW'(i + 8);
      rd2(2'b11, i, i + 7);
      cyc();
    end
    check("bulk_pend_cnt", 64'(bus.pend_cnt), 64'd8);
    for (int i = 12; i < 20; i++) begin
      idle(); rd2(2'b11, i, i + 8);
      cyc();
    end
    check("bulk_r19", 64'(rd(0)), 64'h1300_C0DE);
    check("bulk_r27_busy", 64'(bus.rbusy[1]), 64'd1);
    for (int i = 20; i < 28; i++) begin
      idle();
      bus.we = 1'b1; bus.waddr = AW'(i); bus.wdata = 32'hA000 + 32'(i);
      rd2(2'b10, 0, 47 - i);
      cyc();
    end
    check("bulk_clear_cnt", 64'(bus.pend_cnt), 64'd0);

    // Collision: issue and writeback to r9 on one edge
    idle();
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h99;
    bus.iss_v = 1'b1; bus.iss_addr = 5'd9;
    rd2(2'b11, 5, 7);
    cyc();
    check("coll_pend_cnt", 64'(bus.pend_cnt), 64'd1);
    idle(); rd2(2'b00, 9, 9);
    cyc();
    check("hold_rdata0", 64'(rd(0)), 64'hDEADBEEF);
    check("hold_rdata1", 64'(rd(1)), 64'h77);
    check("hold_stall", 64'(bus.stall), 64'd0);
    rd2(2'b10, 0, 9);
    cyc();
    check("r9_busy1", 64'(bus.rbusy[1]), 64'd1);
    check("r9_stall", 64'(bus.stall), 64'd1);
    check("r9_data", 64'(rd(1)), 64'h99);
    rd2(2'b01, 5, 9);
    cyc();
    check("held_busy1", 64'(bus.rbusy[1]), 64'd1);
    check("stall_masked", 64'(bus.stall), 64'd0);

    // Build three pending registers and r3 = A5A5A5A5, then reset between edges
    idle(); bus.iss_v = 1'b1; bus.iss_addr = 5'd10;
    cyc();
    idle(); bus.iss_v = 1'b1; bus.iss_addr = 5'd11;
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hA5A5A5A5;
    rd2(2'b01, 3, 0);
    cyc();
    check("pre_rst_cnt", 64'(bus.pend_cnt), 64'd3);
    check("pre_rst_r3", 64'(rd(0)), 64'hA5A5A5A5);
    idle();
    #2 rst = 1'b1;
    #1;
    check("arst_rdata0", 64'(rd(0)), 64'h0);
    check("arst_rbusy", 64'(bus.rbusy), 64'h0);
    check("arst_stall", 64'(bus.stall), 64'h0);
    check("arst_pend_cnt", 64'(bus.pend_cnt), 64'h0);
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hFFFF_FFFF;
    bus.iss_v = 1'b1; bus.iss_addr = 5'd4;
    rd2(2'b01, 3, 0);
    cyc();
    rst = 1'b0;
    idle(); rd2(2'b11, 3, 4);
    cyc();
    check("post_rst_r3", 64'(rd(0)), 64'h0);
    check("post_rst_r4_busy", 64'(bus.rbusy[1]), 64'h0);
    check("post_rst_cnt", 64'(bus.pend_cnt), 64'h0);
    idle();
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
